// File: rtl/lcd_pkg.sv
// Shared constants for the LCD message streamer: opcodes, ASCII bytes, FSM states.
// Also holds the mnemonic table and a power-of-ten helper for parameter checks.
package lcd_pkg;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SUBI  = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_DPL   = 3'd7;

  localparam logic [7:0] CURSOR_R = 8'h14;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_MNEM,
    ST_SEP,
    ST_SIGN,
    ST_DIGIT,
    ST_FIN
  } state_t;

  localparam int MNEM_TXT_LEN = 5;

  // Five characters, first character in the top byte, short names padded with cursor-right.
  function automatic logic [8*MNEM_TXT_LEN-1:0] mnem_text(input logic [2:0] op);
    logic [8*MNEM_TXT_LEN-1:0] t;
    case (op)
      OP_LOAD:  t = {"LOAD", CURSOR_R};
      OP_ADD:   t = {"ADD", CURSOR_R, CURSOR_R};
      OP_ADDI:  t = {"ADDI", CURSOR_R};
      OP_SUB:   t = {"SUB", CURSOR_R, CURSOR_R};
      OP_SUBI:  t = {"SUBI", CURSOR_R};
      OP_MUL:   t = {"MUL", CURSOR_R, CURSOR_R};
      OP_CLEAR: t = "CLEAR";
      default:  t = {"DPL", CURSOR_R, CURSOR_R};
    endcase
    return t;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD: loads on start, DATA_W shift steps, done pulses with the last step.
// No backpressure; a new start restarts the conversion and bcd holds until then.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    done
);

  localparam int BW = NUM_DIGITS * 4;
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      cnt  <= CW'(DATA_W);
      bcd  <= '0;
      done <= 1'b0;
    end else if (cnt != '0) begin
      // MSB of the adjusted digits cannot be set: the digit field is wide enough for 2^DATA_W-1.
      bcd  <= (adj << 1) | BW'(sh[DATA_W-1]);
      sh   <= sh << 1;
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_msg_stream.sv
// Streams "mnemonic, cursor-right, [sign], digits" to an LCD; first char DATA_W+1 cycles after start.
// Valid/ready output held stable while stalled; LCD_SIGN_EN selects signed value with a sign char.
module lcd_msg_stream
  import lcd_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5,
  parameter int MNEM_LEN   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic [7:0]        ch_data,
  output logic              ch_is_cmd,
  output logic              ch_valid,
  input  logic              ch_ready,
  output logic              done
);

  localparam int BW   = NUM_DIGITS * 4;
  localparam int MAXL = (MNEM_LEN > NUM_DIGITS) ? MNEM_LEN : NUM_DIGITS;
  localparam int IW   = $clog2(MAXL + 1);

  if (pow10(NUM_DIGITS) <= ((64'd1 << DATA_W) - 64'd1)) begin : g_digit_check
    $error("lcd_msg_stream: NUM_DIGITS too small for DATA_W");
  end

`ifdef LCD_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
  logic in_neg;
  assign in_neg = value[DATA_W-1];
`else
  localparam bit SIGN_EN = 1'b0;
  logic in_neg;
  assign in_neg = 1'b0;
`endif

  state_t            state;
  logic [IW-1:0]     idx;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [DATA_W-1:0] mag;
  logic [BW-1:0]     bcd;
  logic              conv_start;
  logic              conv_done;

  // Two's-complement negate in DATA_W bits maps -2^(DATA_W-1) onto itself, which is the correct magnitude.
  assign mag        = in_neg ? (~value + DATA_W'(1)) : value;
  assign conv_start = start && (state == ST_IDLE);

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (mag),
    .bcd   (bcd),
    .done  (conv_done)
  );

  state_t                    nxt_state;
  logic [IW-1:0]             nxt_idx;
  logic [7:0]                nxt_data;
  logic                      nxt_cmd;
  logic                      load;
  logic [8*MNEM_TXT_LEN-1:0] txt;
  int                        mi;
  int                        dk;
  logic [3:0]                dig;

  // Position after the current character is consumed (or the first position when leaving CONV).
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx + IW'(1);
    case (state)
      ST_CONV: begin
        nxt_state = ST_MNEM;
        nxt_idx   = '0;
      end
      ST_MNEM: begin
        if (idx == IW'(MNEM_LEN - 1)) begin
          nxt_state = (op_q == OP_CLEAR) ? ST_FIN : ST_SEP;
          nxt_idx   = '0;
        end
      end
      ST_SEP: begin
        nxt_state = SIGN_EN ? ST_SIGN : ST_DIGIT;
        nxt_idx   = '0;
      end
      ST_SIGN: begin
        nxt_state = ST_DIGIT;
        nxt_idx   = '0;
      end
      ST_DIGIT: begin
        if (idx == IW'(NUM_DIGITS - 1)) begin
          nxt_state = ST_FIN;
          nxt_idx   = '0;
        end
      end
      default: begin
        nxt_state = state;
        nxt_idx   = idx;
      end
    endcase
  end

  // Character shown at the next position.
  always_comb begin
    nxt_data = 8'h00;
    nxt_cmd  = 1'b0;
    txt      = mnem_text(op_q);
    mi       = int'(nxt_idx);
    dk       = NUM_DIGITS - 1 - int'(nxt_idx);
    dig      = 4'd0;
    case (nxt_state)
      ST_MNEM: begin
        nxt_data = (mi < MNEM_TXT_LEN) ? txt[8*(MNEM_TXT_LEN-1-mi) +: 8] : CURSOR_R;
        nxt_cmd  = (nxt_data == CURSOR_R);
      end
      ST_SEP: begin
        nxt_data = CURSOR_R;
        nxt_cmd  = 1'b1;
      end
      ST_SIGN: begin
        nxt_data = neg_q ? CH_MINUS : CH_PLUS;
      end
      ST_DIGIT: begin
        if (dk >= 0) dig = bcd[4*dk +: 4];
        if ((dk > 0) && ((bcd >> (4*dk)) == '0)) begin
          nxt_data = CURSOR_R;
          nxt_cmd  = 1'b1;
        end else begin
          nxt_data = CH_ZERO | {4'h0, dig};
        end
      end
      default: begin
        nxt_data = 8'h00;
        nxt_cmd  = 1'b0;
      end
    endcase
  end

  assign load = (state == ST_CONV) ? conv_done : (ch_valid && ch_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_q      <= OP_LOAD;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      ch_valid  <= 1'b0;
      ch_data   <= 8'h00;
      ch_is_cmd <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            neg_q <= in_neg;
            busy  <= 1'b1;
            state <= ST_CONV;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          if (load) begin
            if (nxt_state == ST_FIN) begin
              state     <= ST_FIN;
              idx       <= '0;
              ch_valid  <= 1'b0;
              ch_data   <= 8'h00;
              ch_is_cmd <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= nxt_state;
              idx       <= nxt_idx;
              ch_data   <= nxt_data;
              ch_is_cmd <= nxt_cmd;
              ch_valid  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_stream.sv
// Directed bench for lcd_msg_stream; expected streams follow the LCD_SIGN_EN build setting.
module tb_lcd_msg_stream;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [15:0] value = 16'd0;
  logic        busy;
  logic [7:0]  ch_data;
  logic        ch_is_cmd;
  logic        ch_valid;
  logic        ch_ready = 1'b1;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lcd_msg_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .value     (value),
    .busy      (busy),
    .ch_data   (ch_data),
    .ch_is_cmd (ch_is_cmd),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] val,
                      input logic [7:0] exp_q[$], input int stall_at);
    int n, cyc, first, dones;
    bit stalled;
    logic [7:0] held;
    n = 0; cyc = 0; first = -1; dones = 0; stalled = 0; held = 8'h00;
    @(negedge clk);
    start = 1'b1; opcode = op; value = val;
    @(negedge clk);
    start = 1'b0;
    while (dones == 0 && cyc < 300) begin
      if (ch_valid && !stalled && n == stall_at) begin
        stalled = 1; ch_ready = 1'b0; held = ch_data;
        for (int s = 0; s < 3; s++) begin
          if (s == 0) begin start = 1'b1; opcode = OP_CLEAR; end
          else start = 1'b0;
          @(negedge clk); cyc++;
          check("stall_dat", ch_data, held);
          check("stall_vld", ch_valid, 1);
        end
        start = 1'b0; ch_ready = 1'b1;
      end
      if (ch_valid && first < 0) first = cyc;
      if (ch_valid && ch_ready) begin
        if (n < exp_q.size()) begin
          check("chr", ch_data, exp_q[n]);
          check("cmd", ch_is_cmd, exp_q[n] == 8'h14);
        end
        n++;
      end
      if (done) begin
        dones++;
        check("fin_busy", busy, 0);
        check("fin_vld", ch_valid, 0);
      end
      @(negedge clk); cyc++;
    end
    check("latency", first, 17);
    check("len", n, exp_q.size());
    check("done_seen", dones, 1);
    check("done_pulse", done, 0);
  endtask

  initial begin
    logic [7:0] e[$];
    int cnt;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_vld", ch_valid, 0);
    check("rst_done", done, 0);
    check("rst_dat", ch_data, 0);
    check("rst_cmd", ch_is_cmd, 0);
    rst_n = 1'b1;

`ifdef LCD_SIGN_EN
    e = '{8'h41,8'h44,8'h44,8'h14,8'h14,8'h14,8'h2B,8'h14,8'h14,8'h31,8'h32,8'h33};
    send(OP_ADD, 16'd123, e, -1);
    e = '{8'h53,8'h55,8'h42,8'h49,8'h14,8'h14,8'h2D,8'h33,8'h32,8'h37,8'h36,8'h38};
    send(OP_SUBI, 16'h8000, e, -1);
    e = '{8'h43,8'h4C,8'h45,8'h41,8'h52};
    send(OP_CLEAR, 16'd999, e, -1);
    e = '{8'h44,8'h50,8'h4C,8'h14,8'h14,8'h14,8'h2B,8'h14,8'h14,8'h14,8'h14,8'h30};
    send(OP_DPL, 16'd0, e, 8);
    e = '{8'h4C,8'h4F,8'h41,8'h44,8'h14,8'h14,8'h2D,8'h14,8'h14,8'h14,8'h14,8'h31};
    send(OP_LOAD, 16'hFFFF, e, -1);
`else
    e = '{8'h41,8'h44,8'h44,8'h14,8'h14,8'h14,8'h14,8'h14,8'h31,8'h32,8'h33};
    send(OP_ADD, 16'd123, e, -1);
    e = '{8'h53,8'h55,8'h42,8'h49,8'h14,8'h14,8'h33,8'h32,8'h37,8'h36,8'h38};
    send(OP_SUBI, 16'h8000, e, -1);
    e = '{8'h43,8'h4C,8'h45,8'h41,8'h52};
    send(OP_CLEAR, 16'd999, e, -1);
    e = '{8'h44,8'h50,8'h4C,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14,8'h30};
    send(OP_DPL, 16'd0, e, 7);
    e = '{8'h4C,8'h4F,8'h41,8'h44,8'h14,8'h14,8'h36,8'h35,8'h35,8'h33,8'h35};
    send(OP_LOAD, 16'hFFFF, e, -1);
`endif

    // The start pulsed during the DPL stall must not have launched another message.
    repeat (20) @(negedge clk);
    check("idle_vld", ch_valid, 0);
    check("idle_busy", busy, 0);

    // Interrupt a message while it is in the digit field.
    @(negedge clk);
    start = 1'b1; opcode = OP_LOAD; value = 16'd42;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 9; i++) begin
      @(negedge clk);
      if (ch_valid && ch_ready) cnt++;
    end
    check("abort_pos", cnt, 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_vld", ch_valid, 0);
    check("arst_done", done, 0);
    check("arst_dat", ch_data, 0);
    check("arst_cmd", ch_is_cmd, 0);
    repeat (2) @(negedge clk);
    check("arst_nodone", done, 0);
    rst_n = 1'b1;

`ifdef LCD_SIGN_EN
    e = '{8'h4D,8'h55,8'h4C,8'h14,8'h14,8'h14,8'h2B,8'h14,8'h14,8'h14,8'h14,8'h37};
`else
    e = '{8'h4D,8'h55,8'h4C,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14,8'h14,8'h37};
`endif
    send(OP_MUL, 16'd7, e, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lcd_msg_stream.md
LCD_MSG_STREAM -- requirements
Module: lcd_msg_stream

Interface
REQ-001 Parameter DATA_W, default 16: operand width in bits.
REQ-002 Parameter NUM_DIGITS, default 5: decimal digit field width; elaboration SHALL fail if 10^NUM_DIGITS <= 2^DATA_W-1.
REQ-003 Parameter MNEM_LEN, default 5: mnemonic field width in characters.
REQ-004 Ports, in order:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; opcode and value are sampled when start=1 and busy=0.
- opcode  in  3  instruction code: LOAD=0, ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5, CLEAR=6, DPL=7.
- value  in  DATA_W  operand to display.
- busy  out  1  message in progress.
- ch_data  out  8  character byte.
- ch_is_cmd  out  1  1 = ch_data is an LCD command byte (8'h14, cursor right); 0 = ASCII data.
- ch_valid  out  1  character available.
- ch_ready  in  1  sink accepts character.
- done  out  1  one-cycle pulse after the last character transfers.

Function
REQ-005 States: IDLE, CONV, MNEM, SEP, SIGN, DIGIT, FIN.
REQ-006 IDLE: start=1 latches opcode and value, sets busy=1, and enters CONV; start while busy=1 SHALL be ignored.
REQ-007 CONV: sequential binary-to-BCD conversion (shift-add-3) of the magnitude, exactly DATA_W cycles; first ch_valid appears DATA_W+1 cycles after the start edge.
REQ-008 Transfer occurs on a cycle with ch_valid=1 and ch_ready=1; while ch_valid=1 and ch_ready=0, ch_data and ch_is_cmd SHALL hold stable.
REQ-009 MNEM: MNEM_LEN characters; mnemonic letters LOAD, ADD, ADDI, SUB, SUBI, MUL, CLEAR, DPL in upper-case ASCII, left-aligned, padded with 8'h14 (ch_is_cmd=1).
REQ-010 For CLEAR, FIN follows MNEM directly; no value field is emitted.
REQ-011 SEP: one 8'h14 command byte.
REQ-012 SIGN: one ASCII '-' (8'h2D) if the latched value is negative, otherwise '+' (8'h2B).
REQ-013 DIGIT: NUM_DIGITS characters, most significant first, each 8'h30+d; leading zeros are replaced by 8'h14 (ch_is_cmd=1); the last digit is always printed.
REQ-014 Signed magnitude of -2^(DATA_W-1) SHALL be computed in DATA_W unsigned bits without overflow.
REQ-015 FIN: done=1 for one cycle, busy=0 and ch_valid=0 in the same cycle, then return to IDLE; a new start is accepted in the cycle after FIN.
REQ-016 ch_valid SHALL be 0 in IDLE, CONV and FIN.

Reset
REQ-017 rst_n=0 SHALL, asynchronously and regardless of state (including mid-stream or mid-CONV), force state=IDLE, busy=0, ch_valid=0, done=0, ch_data=8'h00, ch_is_cmd=0, and clear the BCD registers.
REQ-018 A message interrupted by reset SHALL NOT resume; the first start after rst_n rises starts a complete message.

Configuration
REQ-019 Macro LCD_SIGN_EN defined: value is two's complement and the SIGN state is emitted; undefined: value is unsigned, the SIGN state is skipped, and the message is one character shorter.

Structure
REQ-020 Shared package lcd_pkg SHALL hold the opcode constants, the ASCII constants, CURSOR_R=8'h14, and the state encoding.
REQ-021 The BCD converter SHALL be sub-module bin2bcd_seq (start, DATA_W input, NUM_DIGITS*4 output, done).

Verification
REQ-022 LCD_SIGN_EN on, opcode=ADD, value=123, ch_ready=1:
- stream 41 44 44 14 14 | 14 | 2B | 14 14 31 32 33, 12 chars.
- done pulses once.
REQ-023 opcode=SUBI, value=16'h8000 -> 53 55 42 49 14 | 14 | 2D | 33 32 37 36 38.
REQ-024 opcode=CLEAR, value=999 -> 43 4C 45 41 52, then done; 5 chars, no value field.
REQ-025 opcode=DPL, value=0, ch_ready low for 3 cycles at the second digit:
- ch_data held stable throughout the stall.
- digits 14 14 14 14 30.
- start pulsed during busy is ignored.
REQ-026 rst_n pulsed low during DIGIT:
- all outputs 0 immediately, no done pulse.
- next start with MUL, 7 -> full 12-char stream from 4D.
REQ-027 LCD_SIGN_EN off, value=65535 -> 11 chars ending 36 35 35 33 35, no 2B/2D.
